// File: rtl/cache_axi_pkg.sv
// Shared constants and state encoding for the cache AXI burst master.
package cache_axi_pkg;

    localparam int CACHE_LINE_WORDS = 4;
    localparam int LINE_OFF_W       = $clog2(CACHE_LINE_WORDS) + 2;
    localparam int BEAT_W           = $clog2(CACHE_LINE_WORDS);
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_AW   = 3'd1;
    localparam state_t ST_W    = 3'd2;
    localparam state_t ST_B    = 3'd3;
    localparam state_t ST_AR   = 3'd4;
    localparam state_t ST_R    = 3'd5;
    localparam state_t ST_DONE = 3'd6;

endpackage

// File: rtl/cache_line_buf.sv
// One cache line of 32-bit words: parallel victim load, per-beat refill write,
// per-beat read for write data and a flat view for the response.
module cache_line_buf
    import cache_axi_pkg::*;
#(
    parameter int LINE_WORDS = CACHE_LINE_WORDS,
    parameter int IDX_W      = $clog2(CACHE_LINE_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [32*LINE_WORDS-1:0] load_line,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [31:0]             wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [31:0]             rd_data,
    output logic [32*LINE_WORDS-1:0] line
);

    logic [31:0] word_r [LINE_WORDS];

    // Line storage: victim capture has priority over refill beats
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                word_r[i] <= 32'd0;
            end
        end else if (load) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                word_r[i] <= load_line[32*i +: 32];
            end
        end else if (wr_en) begin
            word_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = word_r[rd_idx];

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
        assign line[32*g +: 32] = word_r[g];
    end

endmodule

// File: rtl/cache_axi_master.sv
// Cache-line burst master: optional writeback burst then optional refill burst.
// Define CACHE_AXI_BRESP_CHECK_EN to flag non-OKAY write responses on resp_err.
module cache_axi_master
    import cache_axi_pkg::*;
#(
    parameter int LINE_WORDS = CACHE_LINE_WORDS,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wb,
    input  logic                     req_rd,
    input  logic [ADDR_W-1:0]        req_wb_addr,
    input  logic [ADDR_W-1:0]        req_rd_addr,
    input  logic [32*LINE_WORDS-1:0] req_wb_line,
    output logic                     resp_valid,
    output logic [32*LINE_WORDS-1:0] resp_line,
    output logic                     resp_err,
    output logic [31:0]              M_AXI_AWADDR,
    output logic [7:0]               M_AXI_AWLEN,
    output logic                     M_AXI_AWVALID,
    input  logic                     M_AXI_AWREADY,
    output logic [31:0]              M_AXI_WDATA,
    output logic                     M_AXI_WVALID,
    output logic                     M_AXI_WLAST,
    input  logic                     M_AXI_WREADY,
    input  logic [1:0]               M_AXI_BRESP,
    input  logic                     M_AXI_BVALID,
    output logic                     M_AXI_BREADY,
    output logic [31:0]              M_AXI_ARADDR,
    output logic [7:0]               M_AXI_ARLEN,
    output logic                     M_AXI_ARVALID,
    input  logic                     M_AXI_ARREADY,
    input  logic [31:0]              M_AXI_RDATA,
    input  logic                     M_AXI_RLAST,
    input  logic                     M_AXI_RVALID,
    output logic                     M_AXI_RREADY
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0] beat_r, beat_nxt_s;
    logic             accept_s, rd_r;
    logic             req_ready_r, resp_valid_r;
    logic             awvalid_r, wvalid_r, wlast_r, bready_r, arvalid_r, rready_r;
    logic [31:0]      awaddr_r, araddr_r, wdata_r, buf_rd_s;

    assign accept_s = (state_r == ST_IDLE) & req_valid;

    cache_line_buf #(.LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W)) u_line_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_s),
        .load_line (req_wb_line),
        .wr_en     ((state_r == ST_R) & M_AXI_RVALID),
        .wr_idx    (beat_r),
        .wr_data   (M_AXI_RDATA),
        .rd_idx    (beat_nxt_s),
        .rd_data   (buf_rd_s),
        .line      (resp_line)
    );

    // Next state and beat counter; refill beats saturate on the last word
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    beat_nxt_s = {IDX_W{1'b0}};
                    if (req_wb)      state_nxt_s = ST_AW;
                    else if (req_rd) state_nxt_s = ST_AR;
                    else             state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_AW: begin
                if (M_AXI_AWREADY) state_nxt_s = ST_W;
                else               state_nxt_s = ST_AW;
            end
            ST_W: begin
                if (M_AXI_WREADY) begin
                    if (beat_r == LAST_BEAT) begin
                        state_nxt_s = ST_B;
                        beat_nxt_s  = {IDX_W{1'b0}};
                    end else begin
                        beat_nxt_s = beat_r + IDX_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_W;
                end
            end
            ST_B: begin
                if (M_AXI_BVALID) state_nxt_s = rd_r ? ST_AR : ST_DONE;
                else              state_nxt_s = ST_B;
            end
            ST_AR: begin
                if (M_AXI_ARREADY) state_nxt_s = ST_R;
                else               state_nxt_s = ST_AR;
            end
            ST_R: begin
                if (M_AXI_RVALID) begin
                    if (beat_r != LAST_BEAT) beat_nxt_s = beat_r + IDX_W'(1);
                    else                     beat_nxt_s = beat_r;
                    if (M_AXI_RLAST) state_nxt_s = ST_DONE;
                    else             state_nxt_s = ST_R;
                end else begin
                    state_nxt_s = ST_R;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, request capture and registered AXI/cache-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            beat_r       <= {IDX_W{1'b0}};
            rd_r         <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            wlast_r      <= 1'b0;
            bready_r     <= 1'b0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            awaddr_r     <= 32'd0;
            araddr_r     <= 32'd0;
            wdata_r      <= 32'd0;
        end else begin
            state_r      <= state_nxt_s;
            beat_r       <= beat_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_DONE);
            awvalid_r    <= (state_nxt_s == ST_AW);
            wvalid_r     <= (state_nxt_s == ST_W);
            wlast_r      <= (state_nxt_s == ST_W) && (beat_nxt_s == LAST_BEAT);
            bready_r     <= (state_nxt_s == ST_B);
            arvalid_r    <= (state_nxt_s == ST_AR);
            rready_r     <= (state_nxt_s == ST_R);
            wdata_r      <= (state_nxt_s == ST_W) ? buf_rd_s : 32'd0;
            if (accept_s) begin
                rd_r     <= req_rd;
                awaddr_r <= 32'({req_wb_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
                araddr_r <= 32'({req_rd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
            end
        end
    end

`ifdef CACHE_AXI_BRESP_CHECK_EN
    logic err_r;

    // Sticky write-error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_B) && M_AXI_BVALID && (M_AXI_BRESP != AXI_RESP_OKAY)) begin
            err_r <= 1'b1;
        end
    end

    assign resp_err = err_r;
`else
    logic unused_bresp_s;
    assign unused_bresp_s = ^M_AXI_BRESP;
    assign resp_err       = 1'b0;
`endif

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign M_AXI_AWADDR  = awaddr_r;
    assign M_AXI_AWLEN   = 8'(LINE_WORDS - 1);
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_WLAST   = wlast_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_cache_axi_master.sv
// Scoreboard bench for cache_axi_master: AXI slave model, line-level reference
// memory, directed cases then randomized requests.
`timescale 1ns/1ps
module tb_cache_axi_master;

    localparam int LW = 4;
`ifdef CACHE_AXI_BRESP_CHECK_EN
    localparam bit BRESP_EN = 1'b1;
`else
    localparam bit BRESP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, req_valid, req_ready, req_wb, req_rd;
    logic [31:0] req_wb_addr, req_rd_addr;
    logic [32*LW-1:0] req_wb_line, resp_line;
    logic resp_valid, resp_err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0] awlen, arlen;
    logic awvalid, awready, wvalid, wlast, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [1:0] bresp;

    cache_axi_master #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb), .req_rd(req_rd),
        .req_wb_addr(req_wb_addr), .req_rd_addr(req_rd_addr), .req_wb_line(req_wb_line),
        .resp_valid(resp_valid), .resp_line(resp_line), .resp_err(resp_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WLAST(wlast), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int n_cmp = 0, n_bad = 0, n_acc = 0, n_resp = 0;
    int unsigned cyc = 0;
    always @(negedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired before the expected event", name);
    endtask

    // ---------------- reference model (word-addressed memory) ----------------
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] slv_mem [int unsigned];
    bit err_ref = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
    endfunction

    typedef struct {
        bit          rd;
        logic [127:0] line;
        bit          err;
        int unsigned acc;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    // ---------------- AXI slave model ----------------
    int aw_wait = 0, w_wait = 0, w_beat = 0, r_beat = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [31:0] w_addr = 32'd0, r_addr = 32'd0, exp_aw = 32'd0, exp_ar = 32'd0;
    logic [127:0] exp_wline = 128'd0;
    bit b_pend = 1'b0, r_act = 1'b0;

    initial begin : slave
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b1; rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                b_pend = 1'b0; r_act = 1'b0; w_beat = 0; r_beat = 0;
            end else begin
                if (awvalid && awready) begin
                    check("aw_addr", awaddr, exp_aw);
                    check("aw_len", awlen, 8'd3);
                    w_addr = awaddr;
                    w_beat = 0;
                end
                if (wvalid && wready) begin
                    check("w_data", wdata, exp_wline[32*(w_beat%LW) +: 32]);
                    check("w_last", wlast, (w_beat == LW-1));
                    slv_mem[w_addr + 32'(4*w_beat)] = wdata;
                    if (wlast) b_pend = 1'b1;
                    w_beat++;
                end
                if (bvalid && bready) b_pend = 1'b0;
                if (arvalid && arready) begin
                    check("ar_addr", araddr, exp_ar);
                    check("ar_len", arlen, 8'd3);
                    check("ar_after_b", b_pend, 1'b0);
                    r_addr = araddr;
                    r_beat = 0;
                    r_act  = 1'b1;
                end
                if (rvalid && rready) begin
                    if (rlast) r_act = 1'b0;
                    r_beat++;
                end
            end
            @(negedge clk);
            if (awvalid && aw_wait > 0) begin awready = 1'b0; aw_wait--; end
            else awready = 1'b1;
            if (wvalid && w_wait > 0) begin wready = 1'b0; w_wait--; end
            else wready = 1'b1;
            bvalid = b_pend;
            bresp  = bresp_cfg;
            rvalid = r_act;
            rdata  = r_act ? slv_rd(r_addr + 32'(4*r_beat)) : 32'd0;
            rlast  = r_act && (r_beat == LW-1);
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (!reset && resp_valid) begin
                n_resp++;
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.rd) check("resp_line", resp_line, e.line);
                    check("resp_err", resp_err, e.err);
                    if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // ---------------- VALID/payload stability ----------------
    initial begin : stability
        logic p_rst, p_awv, p_awr, p_wv, p_wr, p_wl, p_arv, p_arr;
        logic [31:0] p_awa, p_wd, p_ara;
        p_rst = 1'b1; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
        p_wl = 1'b0; p_arv = 1'b0; p_arr = 1'b0; p_awa = 32'd0; p_wd = 32'd0; p_ara = 32'd0;
        forever begin
            @(posedge clk);
            if (!p_rst) begin
                if (p_awv && !p_awr) check("aw_stable", {awvalid, awaddr}, {1'b1, p_awa});
                if (p_wv && !p_wr)   check("w_stable", {wvalid, wlast, wdata}, {1'b1, p_wl, p_wd});
                if (p_arv && !p_arr) check("ar_stable", {arvalid, araddr}, {1'b1, p_ara});
            end
            p_rst = reset; p_awv = awvalid; p_awr = awready; p_awa = awaddr;
            p_wv = wvalid; p_wr = wready; p_wl = wlast; p_wd = wdata;
            p_arv = arvalid; p_arr = arready; p_ara = araddr;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input bit wb, input bit rd, input logic [31:0] wa, input logic [31:0] ra,
                         input logic [127:0] line, input int aww, input int ww, input logic [1:0] br);
        exp_t e;
        bit accepted;
        aw_wait   = aww;
        w_wait    = ww;
        bresp_cfg = br;
        exp_aw    = {wa[31:4], 4'h0};
        exp_ar    = {ra[31:4], 4'h0};
        exp_wline = line;
        if (wb) begin
            for (int i = 0; i < LW; i++) ref_mem[exp_aw + 32'(4*i)] = line[32*i +: 32];
            if (BRESP_EN && br != 2'b00) err_ref = 1'b1;
        end
        e.rd   = rd;
        e.line = 128'd0;
        if (rd) for (int i = 0; i < LW; i++) e.line[32*i +: 32] = ref_rd(exp_ar + 32'(4*i));
        e.err  = err_ref;
        e.lat  = (aww == 0 && ww == 0) ? (wb ? 6 : 0) + (rd ? 5 : 0) + 1 : -1;
        req_wb = wb; req_rd = rd; req_wb_addr = wa; req_rd_addr = ra; req_wb_line = line;
        req_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 100 && !accepted; k++) begin
            @(posedge clk);
            if (req_ready) accepted = 1'b1;
        end
        if (accepted) begin
            e.acc = cyc;
            sb_q.push_back(e);
            n_acc++;
        end else begin
            timeout("accept");
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (sb_q.size() == 0) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            timeout("response");
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit hit;
        reset = 1'b1; req_valid = 1'b0; req_wb = 1'b0; req_rd = 1'b0;
        req_wb_addr = 32'd0; req_rd_addr = 32'd0; req_wb_line = 128'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_ctl", {awvalid, wvalid, wlast, bready, arvalid, rready, resp_valid, req_ready}, 8'b0000_0001);
        check("reset_len", {awlen, arlen}, {8'd3, 8'd3});
        check("reset_data", {awaddr, araddr, wdata}, 96'd0);
        check("reset_resp", {resp_line, resp_err}, 129'd0);

        for (int i = 0; i < LW; i++) begin
            slv_mem[32'h100 + 32'(4*i)] = 32'h11 * 32'(i+1);
            ref_mem[32'h100 + 32'(4*i)] = 32'h11 * 32'(i+1);
        end
        issue(1'b0, 1'b1, 32'h0, 32'h10C, 128'd0, 0, 0, 2'b00);
        wait_done();
        issue(1'b1, 1'b1, 32'h200, 32'h200, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 2'b00);
        wait_done();
        issue(1'b1, 1'b1, 32'h304, 32'h308, {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000}, 3, 3, 2'b00);
        wait_done();

        // reset during the third refill beat
        issue(1'b0, 1'b1, 32'h0, 32'h100, 128'd0, 0, 0, 2'b00);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if (r_beat == 2) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) timeout("r_beat2");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_ctl", {awvalid, wvalid, wlast, bready, arvalid, rready, resp_valid, req_ready}, 8'b0000_0001);
        reset = 1'b0;
        sb_q.delete();
        err_ref = 1'b0;
        n_acc = n_resp;
        repeat (5) @(negedge clk);
        issue(1'b0, 1'b1, 32'h0, 32'h200, 128'd0, 0, 0, 2'b00);
        wait_done();

        // error response, then a clean transaction with the flag still set
        issue(1'b1, 1'b0, 32'h400, 32'h0, {4{32'h5A5A_0400}}, 0, 0, 2'b10);
        wait_done();
        issue(1'b1, 1'b1, 32'h410, 32'h400, {4{32'h0F0F_0410}}, 0, 0, 2'b00);
        wait_done();

        // stray request while the refill is in progress
        issue(1'b0, 1'b1, 32'h0, 32'h200, 128'd0, 0, 0, 2'b00);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if (r_act) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) timeout("r_active");
        req_valid = 1'b1; req_rd = 1'b1; req_rd_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        check("resp_count", n_resp, n_acc);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] wa, ra;
            wa = 32'h1000 + 32'(16 * $urandom_range(0, 7)) + 32'($urandom_range(0, 15));
            ra = 32'h1000 + 32'(16 * $urandom_range(0, 7)) + 32'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa, ra,
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 1) ? 0 : $urandom_range(1, 3),
                  $urandom_range(0, 1) ? 0 : $urandom_range(1, 3),
                  ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("final_resp_count", n_resp, n_acc);
        check("final_queue_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
